// File: rtl/in_port_debouncer.sv
// in_port_debouncer: synchronises, debounces and change-flags the 4-bit
// input port before it reaches the register Im path on IN instructions.
//
// Ports:
//   CLK      system clock, rising-edge active
//   CLR      asynchronous active-low reset
//   SW_IN    raw, asynchronous, possibly bouncing switch levels
//   ACK_n    active-low acknowledge, clears EVT when sampled low
//   IN_DATA  debounced, registered port value
//   CHANGED  one-cycle pulse after any IN_DATA bit updates
//   EVT      sticky change flag, held until acknowledged
module in_port_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] SW_IN,
    input  logic       ACK_n,
    output logic [3:0] IN_DATA,
    output logic       CHANGED,
    output logic       EVT
);

    // Terminal count: the D-th consecutive mismatch accepts the new level.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       in_data_q, in_data_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic             changed_q, changed_d;
    logic             evt_q, evt_d;
    logic [3:0]       accept;
    logic             upd;

    always_comb begin
        sync1_d   = SW_IN;
        sync2_d   = sync1_q;
        in_data_d = in_data_q;
        accept    = '0;
        for (int i = 0; i < 4; i++) begin
            // A matching sample (bounce back) always restarts the count.
            cnt_d[i] = '0;
            if (sync2_q[i] != in_data_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    accept[i]    = 1'b1;
                    in_data_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        upd       = |accept;
        changed_d = upd;
        // Set has priority over an acknowledge on the same edge.
        if (upd) begin
            evt_d = 1'b1;
        end else if (!ACK_n) begin
            evt_d = 1'b0;
        end else begin
            evt_d = evt_q;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            in_data_q <= '0;
            changed_q <= 1'b0;
            evt_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            in_data_q <= in_data_d;
            changed_q <= changed_d;
            evt_q     <= evt_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign IN_DATA = in_data_q;
    assign CHANGED = changed_q;
    assign EVT     = evt_q;

endmodule
